// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types and helpers for the serial-to-parallel shift register controller.
package shiftreg_ctrl_pkg;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        PAR   = 2'd1,
        FULL  = 2'd2
    } state_e;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/shiftreg_ctrl_shiftreg.sv
// Serial-in parallel-out shift register; newest bit enters at [0].
// No reset: contents are only meaningful as qualified by the controller's bit count.
module shiftreg_ctrl_shiftreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/shiftreg_ctrl.sv
// Deserializer controller: bit handshake in, word handshake out, one holding stage.
// Optional even-parity beat per word when SHIFTREG_CTRL_PARITY_EN is defined.
module shiftreg_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter  int DW = 64,
    localparam int CW = cnt_width(DW)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_perr,
    output logic [CW-1:0] count
);

`ifdef SHIFTREG_CTRL_PARITY_EN
    // One extra stage keeps the data bits intact after the parity beat shifts in.
    localparam int SRW = DW + 1;
`else
    localparam int SRW = DW;
`endif

    localparam logic [CW-1:0] LAST_IDX = CW'(DW - 1);

    state_e         state;
    state_e         state_nxt;
    logic           beat;
    logic           last_data;
    logic           word_done;
    logic           hold_free;
    logic           out_acc;
    logic           load;
    logic [DW-1:0]  word_nxt;
    logic [SRW-1:0] sr_q;

    shiftreg_ctrl_shiftreg #(
        .W(SRW)
    ) u_sr (
        .clk(clk),
        .en (beat),
        .din(in_data),
        .q  (sr_q)
    );

    assign beat      = in_valid && in_ready;
    assign last_data = (state == SHIFT) && beat && (count == LAST_IDX);
    assign hold_free = !out_valid || out_ready;
    assign out_acc   = out_valid && out_ready;

`ifdef SHIFTREG_CTRL_PARITY_EN
    logic par_acc;
    logic perr_nxt;

    assign word_done = (state == PAR) && beat;
    assign word_nxt  = (state == FULL) ? sr_q[DW:1] : sr_q[DW-1:0];
    assign perr_nxt  = par_acc ^ ((state == FULL) ? sr_q[0] : in_data);
`else
    assign word_done = last_data;
    // On the completing beat the register has not yet taken the last bit.
    assign word_nxt  = (state == FULL) ? sr_q : {sr_q[DW-2:0], in_data};
`endif

    assign load = (word_done && hold_free) || ((state == FULL) && out_acc);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SHIFT: begin
                if (clear) begin
                    state_nxt = SHIFT;
                end else if (last_data) begin
`ifdef SHIFTREG_CTRL_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = hold_free ? SHIFT : FULL;
`endif
                end
            end
            PAR: begin
                if (clear) begin
                    state_nxt = SHIFT;
                end else if (beat) begin
                    state_nxt = hold_free ? SHIFT : FULL;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = SHIFT;
        endcase
    end

    always_comb begin
        in_ready = !clear && (state != FULL);
    end

    // Bit counter: parks at DW while a finished word waits in FULL.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (state == FULL) begin
            if (out_acc) begin
                count <= '0;
            end
        end else if (clear || (word_done && hold_free)) begin
            count <= '0;
        end else if (beat && (state == SHIFT)) begin
            count <= count + CW'(1);
        end
    end

`ifdef SHIFTREG_CTRL_PARITY_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            par_acc <= 1'b0;
        end else if (state == FULL) begin
            if (out_acc) begin
                par_acc <= 1'b0;
            end
        end else if (clear || (word_done && hold_free)) begin
            par_acc <= 1'b0;
        end else if (beat && (state == SHIFT)) begin
            par_acc <= par_acc ^ in_data;
        end
    end
`endif

    // Holding stage: loads on completion or reload from FULL, empties on accept.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SHIFTREG_CTRL_PARITY_EN
            out_perr  <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word_nxt;
`ifdef SHIFTREG_CTRL_PARITY_EN
            out_perr  <= perr_nxt;
`endif
        end else if (out_acc) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SHIFTREG_CTRL_PARITY_EN
    assign out_perr = 1'b0;
`endif

endmodule
